// File: rtl/param_register_if.sv
// Data/enable bundle for a param_register: the master side writes words in,
// the slave side (the register) presents the stored word back.
interface param_register_if #(
  parameter int unsigned Size = 32
);
  logic [Size-1:0] data_i;
  logic            load;
  logic [Size-1:0] data_o;

  modport master (
    output data_i,
    output load,
    input  data_o
  );

  modport slave (
    input  data_i,
    input  load,
    output data_o
  );
endinterface

// File: rtl/param_register.sv
// Loadable N-bit word register with a synchronous active-low reset.
// The output comes straight from the flops; data_i never reaches data_o combinationally.
module param_register #(
  parameter int unsigned     Size     = 32,
  parameter logic [Size-1:0] ResetVal = '0
) (
  input  logic               clk,
  input  logic               reset,
  param_register_if.slave    bus
);

  logic [Size-1:0] data_q;

  // Reset wins over load on the same edge; without either, the word is held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= ResetVal;
    end else if (bus.load) begin
      data_q <= bus.data_i;
    end
  end

  assign bus.data_o = data_q;

endmodule

// File: tb/tb_param_register.sv
// Directed and random checks of param_register at 32 and 64 bits.
module tb_param_register;

  localparam logic [63:0] Reset64 = 64'h0123_4567_89AB_CDEF;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #1 clk = ~clk;

  param_register_if #(.Size(32)) bus32 ();
  param_register_if #(.Size(64)) bus64 ();

  param_register #(.Size(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  param_register #(.Size(64), .ResetVal(Reset64)) dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus64.slave)
  );

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_n, input logic ld32, input logic [31:0] d32,
                               input logic ld64, input logic [63:0] d64);
    reset        = rst_n;
    bus32.load   = ld32;
    bus32.data_i = d32;
    bus64.load   = ld64;
    bus64.data_i = d64;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 64'hFFFF_0000_FFFF_0000);
    tick();
    checks++;
    if (bus32.data_o !== 32'h0000_0000) begin
      errors++;
      $display("[TB] FAIL reset32: got %h expected %h", bus32.data_o, 32'h0);
    end
    checks++;
    if (bus64.data_o !== Reset64) begin
      errors++;
      $display("[TB] FAIL reset64: got %h expected %h", bus64.data_o, Reset64);
    end
  endtask

  task automatic test_load();
    applyStimulus(1'b1, 1'b1, 32'hA5A5_1234, 1'b0, 64'h1111_2222_3333_4444);
    tick();
    checks++;
    if (bus32.data_o !== 32'hA5A5_1234) begin
      errors++;
      $display("[TB] FAIL load32: got %h expected %h", bus32.data_o, 32'hA5A5_1234);
    end
    checks++;
    if (bus64.data_o !== Reset64) begin
      errors++;
      $display("[TB] FAIL hold64_noload: got %h expected %h", bus64.data_o, Reset64);
    end
  endtask

  task automatic test_hold();
    applyStimulus(1'b1, 1'b0, 32'h0F0F_0F0F, 1'b0, 64'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus32.data_o !== 32'hA5A5_1234) begin
        errors++;
        $display("[TB] FAIL hold32[%0d]: got %h expected %h", i, bus32.data_o, 32'hA5A5_1234);
      end
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, 1'b1, 32'h0000_0001, 1'b1, 64'h0000_0000_0000_0001);
    tick();
    checks++;
    if (bus32.data_o !== 32'h0000_0001) begin
      errors++;
      $display("[TB] FAIL b2b32_first: got %h expected %h", bus32.data_o, 32'h1);
    end
    checks++;
    if (bus64.data_o !== 64'h1) begin
      errors++;
      $display("[TB] FAIL b2b64_first: got %h expected %h", bus64.data_o, 64'h1);
    end
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    checks++;
    if (bus32.data_o !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL b2b32_second: got %h expected %h", bus32.data_o, 32'hFFFF_FFFF);
    end
    checks++;
    if (bus64.data_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL b2b64_second: got %h expected %h", bus64.data_o, 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_reset_priority();
    applyStimulus(1'b0, 1'b1, 32'h5555_AAAA, 1'b1, 64'h5555_AAAA_5555_AAAA);
    tick();
    checks++;
    if (bus32.data_o !== 32'h0000_0000) begin
      errors++;
      $display("[TB] FAIL prio32_reset: got %h expected %h", bus32.data_o, 32'h0);
    end
    checks++;
    if (bus64.data_o !== Reset64) begin
      errors++;
      $display("[TB] FAIL prio64_reset: got %h expected %h", bus64.data_o, Reset64);
    end
    applyStimulus(1'b1, 1'b0, 32'h5555_AAAA, 1'b0, 64'h5555_AAAA_5555_AAAA);
    tick();
    checks++;
    if (bus32.data_o !== 32'h0000_0000) begin
      errors++;
      $display("[TB] FAIL prio32_release: got %h expected %h", bus32.data_o, 32'h0);
    end
    checks++;
    if (bus64.data_o !== Reset64) begin
      errors++;
      $display("[TB] FAIL prio64_release: got %h expected %h", bus64.data_o, Reset64);
    end
  endtask

  task automatic test_random32();
    logic [31:0] val;
    for (int i = 0; i < 1000; i++) begin
      val = $urandom;
      applyStimulus(1'b1, 1'b1, val, 1'b0, 64'h0);
      tick();
      checks++;
      if (bus32.data_o !== val) begin
        errors++;
        $display("[TB] FAIL rand32_load[%0d]: got %h expected %h", i, bus32.data_o, val);
      end
      applyStimulus(1'b1, 1'b0, ~val ^ 32'($urandom), 1'b0, 64'h0);
      tick();
      checks++;
      if (bus32.data_o !== val) begin
        errors++;
        $display("[TB] FAIL rand32_hold[%0d]: got %h expected %h", i, bus32.data_o, val);
      end
    end
  endtask

  task automatic test_random64();
    logic [63:0] val;
    for (int i = 0; i < 1000; i++) begin
      val = {32'($urandom), 32'($urandom)};
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, val);
      tick();
      checks++;
      if (bus64.data_o !== val) begin
        errors++;
        $display("[TB] FAIL rand64_load[%0d]: got %h expected %h", i, bus64.data_o, val);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, ~val ^ {32'($urandom), 32'($urandom)});
      tick();
      checks++;
      if (bus64.data_o !== val) begin
        errors++;
        $display("[TB] FAIL rand64_hold[%0d]: got %h expected %h", i, bus64.data_o, val);
      end
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 64'h0);
    test_reset();
    test_load();
    test_hold();
    test_back_to_back();
    test_reset_priority();
    test_random32();
    test_random64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
